// File: rtl/clk_en_pkg.sv
// clk_en_pkg: shared width, divisor type and standard audio divisors for clk_en_gen
package clk_en_pkg;
  localparam int DEF_CNT_W = 10;
  typedef logic [DEF_CNT_W-1:0] div_t;
  localparam div_t DIV_FS_48K = 10'd512;
  localparam div_t DIV_BCLK_1M536 = 10'd16;
endpackage

// File: rtl/clk_en_chan.sv
// clk_en_chan: one enable channel; counter, shadow/active divisor, en and optional clk_out (CLK_EN_GEN_TOGGLE_EN)
// Ports: master_clk, rst (async active-low), run, sync, wr, cfg_div -> en, div_cur[, clk_out]
import clk_en_pkg::*;
module clk_en_chan #(
  parameter int CNT_W = DEF_CNT_W,
  parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_FS_48K)
) (
  input  logic             master_clk,
  input  logic             rst,
  input  logic             run,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             en,
  output logic [CNT_W-1:0] div_cur
`ifdef CLK_EN_GEN_TOGGLE_EN
  , output logic           clk_out
`endif
);
  logic [CNT_W-1:0] cnt, shd, act, shd_nxt;
  logic wrap;
  assign shd_nxt = wr ? cfg_div : shd;
  assign wrap = cnt == act - CNT_W'(1);
  assign div_cur = act;
  // active divisor only changes at a wrap, on sync, or while disabled, so a period is never cut or stretched
  always_ff @(posedge master_clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      en <= 1'b0;
      shd <= DIV_RST;
      act <= DIV_RST;
    end else begin
      shd <= shd_nxt;
      if (sync) begin
        cnt <= '0;
        en <= 1'b0;
        act <= shd_nxt;
      end else if (act == '0) begin
        cnt <= '0;
        en <= 1'b0;
        act <= shd;
      end else if (!run) begin
        en <= 1'b0;
      end else if (wrap) begin
        cnt <= '0;
        en <= 1'b1;
        act <= shd;
      end else begin
        cnt <= cnt + CNT_W'(1);
        en <= 1'b0;
      end
    end
  end
`ifdef CLK_EN_GEN_TOGGLE_EN
  // high for the first floor(div/2) counts of each period
  always_ff @(posedge master_clk or negedge rst) begin
    if (!rst) clk_out <= 1'b0;
    else clk_out <= !sync && run && act != '0 && cnt < (act >> 1);
  end
`endif
endmodule

// File: rtl/clk_en_gen.sv
// clk_en_gen: multi-channel programmable clock-enable generator with glitch-free divisor update and sync
// Ports: master_clk, rst (async active-low), run, sync, cfg_wr/cfg_ch/cfg_div -> en[NUM_CH], div_cur[NUM_CH*CNT_W]
//        clk_out[NUM_CH] present only when CLK_EN_GEN_TOGGLE_EN is defined
import clk_en_pkg::*;
module clk_en_gen #(
  parameter int NUM_CH = 2,
  parameter int CNT_W = DEF_CNT_W,
  parameter logic [NUM_CH-1:0][CNT_W-1:0] DIV_RST = {CNT_W'(DIV_BCLK_1M536), CNT_W'(DIV_FS_48K)},
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                    master_clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic                    sync,
  input  logic                    cfg_wr,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [CNT_W-1:0]        cfg_div,
  output logic [NUM_CH-1:0]       en,
  output logic [NUM_CH*CNT_W-1:0] div_cur
`ifdef CLK_EN_GEN_TOGGLE_EN
  , output logic [NUM_CH-1:0]     clk_out
`endif
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_en_chan #(.CNT_W(CNT_W), .DIV_RST(DIV_RST[i])) u_chan (
      .master_clk(master_clk),
      .rst(rst),
      .run(run),
      .sync(sync),
      .wr(cfg_wr && cfg_ch == CH_W'(i)),
      .cfg_div(cfg_div),
      .en(en[i]),
      .div_cur(div_cur[i*CNT_W +: CNT_W])
`ifdef CLK_EN_GEN_TOGGLE_EN
      , .clk_out(clk_out[i])
`endif
    );
  end
endmodule

// File: tb/tb_clk_en_gen.sv
// tb_clk_en_gen: directed + random stimulus for clk_en_gen checked against a countdown reference model
module tb_clk_en_gen;
  logic master_clk = 1'b0;
  logic rst, run, sync, cfg_wr;
  logic [0:0] cfg_ch;
  logic [9:0] cfg_div;
  logic [1:0] en;
  logic [19:0] div_cur;
`ifdef CLK_EN_GEN_TOGGLE_EN
  logic [1:0] clk_out;
`endif
  int errors = 0;
  int checks = 0;
  int div[2], pend[2], rem[2];
  bit exp_en[2], exp_clk[2];

  clk_en_gen dut (
    .master_clk(master_clk),
    .rst(rst),
    .run(run),
    .sync(sync),
    .cfg_wr(cfg_wr),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .en(en),
    .div_cur(div_cur)
`ifdef CLK_EN_GEN_TOGGLE_EN
    , .clk_out(clk_out)
`endif
  );

  always #5 master_clk = ~master_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    div[0] = 512; div[1] = 16;
    for (int c = 0; c < 2; c++) begin
      pend[c] = div[c];
      rem[c] = div[c];
      exp_en[c] = 0;
      exp_clk[c] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("%s en[%0d]", tag, c), int'(en[c]), int'(exp_en[c]));
      chk($sformatf("%s div_cur[%0d]", tag, c), int'(div_cur[c*10 +: 10]), div[c]);
`ifdef CLK_EN_GEN_TOGGLE_EN
      chk($sformatf("%s clk_out[%0d]", tag, c), int'(clk_out[c]), int'(exp_clk[c]));
`endif
    end
  endtask

  // rem = run cycles left until this channel's next pulse; pend = last written divisor
  task automatic step(input string tag, input bit r, input bit s, input bit w, input int c, input int d);
    int np;
    run = r; sync = s; cfg_wr = w; cfg_ch = c[0:0]; cfg_div = d[9:0];
    @(posedge master_clk);
    for (int ch = 0; ch < 2; ch++) begin
      np = (w && c == ch) ? d : pend[ch];
      if (s) begin
        div[ch] = np; rem[ch] = np; exp_en[ch] = 0; exp_clk[ch] = 0;
      end else if (div[ch] == 0) begin
        exp_en[ch] = 0; exp_clk[ch] = 0; div[ch] = pend[ch]; rem[ch] = div[ch];
      end else if (!r) begin
        exp_en[ch] = 0; exp_clk[ch] = 0;
      end else begin
        exp_clk[ch] = (div[ch] - rem[ch]) < div[ch] / 2;
        rem[ch]--;
        exp_en[ch] = rem[ch] == 0;
        if (rem[ch] == 0) begin
          div[ch] = pend[ch];
          rem[ch] = div[ch];
        end
      end
      pend[ch] = np;
    end
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input bit r, input int n);
    for (int k = 0; k < n; k++) step(tag, r, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; sync = 1'b0; cfg_wr = 1'b0; cfg_ch = 1'b0; cfg_div = '0;
    model_reset();
    #7;
    check_all("reset");
    #5 rst = 1'b1;
    idle("defaults", 1, 1100);
    idle("pre_wr", 1, 5);
    step("wr_ch1_8", 1, 0, 1, 1, 8);
    idle("div8", 1, 40);
    idle("pre_sync", 1, 37);
    step("sync", 1, 1, 0, 0, 0);
    idle("post_sync", 1, 600);
    step("wr_ch1_0", 1, 0, 1, 1, 0);
    idle("disabled", 1, 30);
    step("wr_ch1_4", 1, 0, 1, 1, 4);
    idle("div4", 1, 20);
    step("wr_ch1_1", 1, 0, 1, 1, 1);
    idle("div1", 1, 10);
    step("wr_ch1_16", 1, 0, 1, 1, 16);
    idle("pre_freeze", 1, 23);
    idle("frozen", 0, 100);
    idle("resume", 1, 600);
    step("wr_ch0_5", 1, 0, 1, 0, 5);
    step("sync_wr", 1, 1, 1, 1, 5);
    idle("div5", 1, 30);
    for (int k = 0; k < 3000; k++)
      step("random", $urandom_range(0, 9) != 0, $urandom_range(0, 99) == 0,
           $urandom_range(0, 7) == 0, int'($urandom_range(0, 1)), int'($urandom_range(0, 12)));
    step("wr_ch1_1b", 1, 1, 1, 1, 1);
    idle("div1b", 1, 5);
    rst = 1'b0;
    #1;
    chk("async_rst en[1]", int'(en[1]), 0);
    chk("async_rst en[0]", int'(en[0]), 0);
    model_reset();
    check_all("async_rst");
    #2 rst = 1'b1;
    idle("after_rst", 1, 40);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
